// File: rtl/axi_reg_pkg.sv
// Shared types for the register-bank slave.
// Response codes and write/read channel state encodings.
package axi_reg_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/reg_write_channel.sv
// Write-side handshake FSM with address/data latches.
// Emits a one-cycle commit on the edge that enters W_RESP.
module reg_write_channel
  import axi_reg_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int NUM_RW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            aw_valid_i,
  output logic            aw_ready_o,
  input  logic [AW-1:0]   aw_addr_i,
  input  logic            w_valid_i,
  output logic            w_ready_o,
  input  logic [DW-1:0]   w_data_i,
  input  logic [DW/8-1:0] w_strb_i,
  output logic            b_valid_o,
  input  logic            b_ready_i,
  output resp_t           b_resp_o,
  output logic            commit_o,
  output logic            c_ok_o,
  output logic [AW-1:0]   c_addr_o,
  output logic [DW-1:0]   c_data_o,
  output logic [DW/8-1:0] c_strb_o
);

  wr_state_t       state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] strb_q;
  resp_t           resp_q;
  logic            aw_hs, w_hs;

  assign aw_ready_o = ~rst &
    ((state_q == W_IDLE) | (state_q == W_DATA));
  assign w_ready_o  = ~rst &
    ((state_q == W_IDLE) | (state_q == W_ADDR));

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i & w_ready_o;

  // Final handshake forwards the live bus value, earlier ones the latch.
  assign c_addr_o = aw_hs ? aw_addr_i : addr_q;
  assign c_data_o = w_hs ? w_data_i : data_q;
  assign c_strb_o = w_hs ? w_strb_i : strb_q;
  assign c_ok_o   = 32'(c_addr_o) < NUM_RW;

  assign b_valid_o = (state_q == W_RESP);
  assign b_resp_o  = resp_q;

  always_comb begin
    state_d  = state_q;
    commit_o = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          state_d  = W_RESP;
          commit_o = 1'b1;
        end else if (aw_hs) begin
          state_d = W_ADDR;
        end else if (w_hs) begin
          state_d = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_hs) begin
          state_d  = W_RESP;
          commit_o = 1'b1;
        end
      end
      W_DATA: begin
        if (aw_hs) begin
          state_d  = W_RESP;
          commit_o = 1'b1;
        end
      end
      W_RESP: begin
        if (b_ready_i) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= W_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (aw_hs) addr_q <= aw_addr_i;
      if (w_hs) begin
        data_q <= w_data_i;
        strb_q <= w_strb_i;
      end
      if (commit_o)
        resp_q <= c_ok_o ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: rtl/axi_reg_slave.sv
// Register-bank slave: NUM_RW control and NUM_RO status words.
// Define REG_SLAVE_WSTRB_EN to add the wStrb byte-lane port.
module axi_reg_slave
  import axi_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RW     = 4,
  parameter int NUM_RO     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         awValid,
  output logic                         awReady,
  input  logic [ADDR_WIDTH-1:0]        awAddr,
  input  logic                         wValid,
  output logic                         wReady,
  input  logic [DATA_WIDTH-1:0]        wData,
`ifdef REG_SLAVE_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]      wStrb,
`endif
  output logic                         bValid,
  input  logic                         bReady,
  output logic [1:0]                   bResp,
  input  logic                         arValid,
  output logic                         arReady,
  input  logic [ADDR_WIDTH-1:0]        arAddr,
  output logic                         rValid,
  input  logic                         rReady,
  output logic [DATA_WIDTH-1:0]        rData,
  output logic [1:0]                   rResp,
  output logic [NUM_RW*DATA_WIDTH-1:0] ctrlRegs,
  input  logic [NUM_RO*DATA_WIDTH-1:0] statusRegs,
  output logic [NUM_RW-1:0]            writePulse
);

  localparam int SW = DATA_WIDTH / 8;

  logic [SW-1:0]         strb;
  logic                  commit, c_ok;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [SW-1:0]         c_strb;

`ifdef REG_SLAVE_WSTRB_EN
  assign strb = wStrb;
`else
  assign strb = '1;
`endif

  reg_write_channel #(
    .DW     (DATA_WIDTH),
    .AW     (ADDR_WIDTH),
    .NUM_RW (NUM_RW)
  ) u_wr (
    .clk        (clk),
    .rst        (rst),
    .aw_valid_i (awValid),
    .aw_ready_o (awReady),
    .aw_addr_i  (awAddr),
    .w_valid_i  (wValid),
    .w_ready_o  (wReady),
    .w_data_i   (wData),
    .w_strb_i   (strb),
    .b_valid_o  (bValid),
    .b_ready_i  (bReady),
    .b_resp_o   (bResp),
    .commit_o   (commit),
    .c_ok_o     (c_ok),
    .c_addr_o   (c_addr),
    .c_data_o   (c_data),
    .c_strb_o   (c_strb)
  );

  logic [DATA_WIDTH-1:0] ctrl_q [NUM_RW];
  logic [DATA_WIDTH-1:0] ctrl_d [NUM_RW];
  logic [NUM_RW-1:0]     pulse_q, pulse_d;

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      ctrl_d[i] = ctrl_q[i];
      if (commit && c_ok && (32'(c_addr) == i)) begin
        pulse_d[i] = 1'b1;
        for (int b = 0; b < SW; b++)
          if (c_strb[b])
            ctrl_d[i][b*8 +: 8] = c_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= '0;
      for (int i = 0; i < NUM_RW; i++)
        ctrl_q[i] <= '0;
    end else begin
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_RW; i++)
        ctrl_q[i] <= ctrl_d[i];
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_pack
    assign ctrlRegs[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
  end

  assign writePulse = pulse_q;

  rd_state_t             rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;
  logic                  ar_hs;

  assign arReady = ~rst & (rd_q == R_IDLE);
  assign ar_hs   = arValid & arReady;
  assign rValid  = (rd_q == R_DATA);
  assign rData   = rdata_q;
  assign rResp   = rresp_q;

  always_comb begin
    rd_d = rd_q;
    unique case (rd_q)
      R_IDLE:  if (ar_hs) rd_d = R_DATA;
      R_DATA:  if (rReady) rd_d = R_IDLE;
      default: rd_d = R_IDLE;
    endcase
  end

  // Decode reads the pre-commit register value on a shared edge.
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_SLVERR;
    for (int i = 0; i < NUM_RW; i++) begin
      if (32'(arAddr) == i) begin
        rdata_d = ctrl_q[i];
        rresp_d = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (32'(arAddr) == NUM_RW + j) begin
        rdata_d = statusRegs[j*DATA_WIDTH +: DATA_WIDTH];
        rresp_d = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      rd_q <= rd_d;
      if (ar_hs) begin
        rdata_q <= rdata_d;
        rresp_q <= rresp_d;
      end
    end
  end

endmodule

// File: tb/tb_axi_reg_slave.sv
// Self-checking bench for axi_reg_slave against a word-level model.
// Exercises the strobe path when REG_SLAVE_WSTRB_EN is defined.
module tb_axi_reg_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic         awValid, awReady;
  logic [3:0]   awAddr;
  logic         wValid, wReady;
  logic [31:0]  wData;
`ifdef REG_SLAVE_WSTRB_EN
  logic [3:0]   wStrb;
`endif
  logic         bValid, bReady;
  logic [1:0]   bResp;
  logic         arValid, arReady;
  logic [3:0]   arAddr;
  logic         rValid, rReady;
  logic [31:0]  rData;
  logic [1:0]   rResp;
  logic [127:0] ctrlRegs;
  logic [127:0] statusRegs;
  logic [3:0]   writePulse;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [4];

  always #5 clk = ~clk;

  axi_reg_slave dut (
    .clk        (clk),
    .rst        (rst),
    .awValid    (awValid),
    .awReady    (awReady),
    .awAddr     (awAddr),
    .wValid     (wValid),
    .wReady     (wReady),
    .wData      (wData),
`ifdef REG_SLAVE_WSTRB_EN
    .wStrb      (wStrb),
`endif
    .bValid     (bValid),
    .bReady     (bReady),
    .bResp      (bResp),
    .arValid    (arValid),
    .arReady    (arReady),
    .arAddr     (arAddr),
    .rValid     (rValid),
    .rReady     (rReady),
    .rData      (rData),
    .rResp      (rResp),
    .ctrlRegs   (ctrlRegs),
    .statusRegs (statusRegs),
    .writePulse (writePulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] packed_model();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = model[i];
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  // Spec-level effect of a write: control words change, others error.
  task automatic model_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s,
                             output logic [1:0] er,
                             output logic [3:0] ep);
    er = 2'b10;
    ep = 4'b0;
    if (a < 4) begin
      model[a] = merge(model[a], d, s);
      er = 2'b00;
      ep = 4'b0001 << a;
    end
  endtask

  task automatic model_read(input logic [3:0] a, input logic [127:0] st,
                            output logic [31:0] ed,
                            output logic [1:0] er);
    ed = 32'h0;
    er = 2'b10;
    if (a < 4) begin
      ed = model[a];
      er = 2'b00;
    end else if (a < 8) begin
      ed = st[(a-4)*32 +: 32];
      er = 2'b00;
    end
  endtask

  task automatic write_txn(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp,
                           output logic [3:0] pulse,
                           output logic bv,
                           output logic [127:0] regs,
                           output logic bv_after,
                           output logic [3:0] pulse_after);
    bit aw_done = 0;
    bit w_done  = 0;
    bit hs_aw, hs_w;
    int cyc = 0;
    bReady = 1'b1;
    while (!(aw_done && w_done) && cyc < 50) begin
      awValid = !aw_done && cyc >= aw_dly;
      awAddr  = a;
      wValid  = !w_done && cyc >= w_dly;
      wData   = d;
`ifdef REG_SLAVE_WSTRB_EN
      wStrb   = s;
`endif
      hs_aw = awValid && awReady;
      hs_w  = wValid && wReady;
      tick();
      aw_done = aw_done | hs_aw;
      w_done  = w_done | hs_w;
      cyc++;
    end
    awValid = 1'b0;
    wValid  = 1'b0;
    if (!(aw_done && w_done)) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout addr=%0d got no handshake want both", a);
    end
    resp  = bResp;
    pulse = writePulse;
    bv    = bValid;
    regs  = ctrlRegs;
    tick();
    bv_after    = bValid;
    pulse_after = writePulse;
  endtask

  // Status inputs are scrambled right after the handshake edge.
  task automatic read_txn(input logic [3:0] a, input int hold,
                          output logic [31:0] data,
                          output logic [1:0] resp,
                          output logic rv, output bit stable,
                          output logic rv_after);
    int cyc = 0;
    bit hs = 0;
    rReady  = 1'b0;
    arValid = 1'b1;
    arAddr  = a;
    while (!hs && cyc < 20) begin
      hs = arReady;
      tick();
      cyc++;
    end
    arValid = 1'b0;
    statusRegs = {$urandom, $urandom, $urandom, $urandom};
    if (!hs) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_timeout addr=%0d got no arReady want one", a);
    end
    rv     = rValid;
    data   = rData;
    resp   = rResp;
    stable = 1;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (!rValid || rData !== data || rResp !== resp || arReady)
        stable = 0;
    end
    rReady = 1'b1;
    tick();
    rReady   = 1'b0;
    rv_after = rValid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({awReady, wReady, arReady} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_readies got=%b want=000",
               {awReady, wReady, arReady});
    end
    n_checks++;
    if ({bValid, rValid, bResp, rResp} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_resp got=%b want=0",
               {bValid, rValid, bResp, rResp});
    end
    n_checks++;
    if (ctrlRegs !== 128'h0 || writePulse !== 4'h0 || rData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs got ctrl=%h pulse=%b rdata=%h want 0",
               ctrlRegs, writePulse, rData);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({awReady, wReady, arReady} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release got=%b want=111",
               {awReady, wReady, arReady});
    end
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
  endtask

  task automatic test_basic_write();
    logic [1:0] r, er;
    logic [3:0] p, ep, pa;
    logic bv, bva;
    logic [127:0] regs;
    model_write(4'd1, 32'hDEADBEEF, 4'hF, er, ep);
    write_txn(4'd1, 32'hDEADBEEF, 4'hF, 0, 0, r, p, bv, regs, bva, pa);
    n_checks++;
    if (regs[63:32] !== 32'hDEADBEEF || regs !== packed_model()) begin
      n_fail++;
      $display("FAIL basic_data got=%h want=%h", regs, packed_model());
    end
    n_checks++;
    if (p !== 4'b0010 || bv !== 1'b1 || r !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_resp got p=%b bv=%b r=%b want 0010 1 00",
               p, bv, r);
    end
    n_checks++;
    if (pa !== 4'b0 || bva !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle got p=%b bv=%b want 0000 0", pa, bva);
    end
  endtask

  task automatic test_split_write();
    logic [31:0] d;
    logic [1:0] rr, er;
    logic [3:0] ep;
    logic rv, rva;
    bit st, low = 1;
    bReady  = 1'b1;
    awValid = 1'b1;
    awAddr  = 4'd2;
    tick();
    awValid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        wValid = 1'b1;
        wData  = 32'h12345678;
`ifdef REG_SLAVE_WSTRB_EN
        wStrb  = 4'hF;
`endif
      end
      if (awReady !== 1'b0) low = 0;
      if (c < 3) tick();
    end
    tick();
    wValid = 1'b0;
    model_write(4'd2, 32'h12345678, 4'hF, er, ep);
    n_checks++;
    if (!low) begin
      n_fail++;
      $display("FAIL split_awready got high want low");
    end
    n_checks++;
    if (bValid !== 1'b1 || writePulse !== ep ||
        ctrlRegs !== packed_model()) begin
      n_fail++;
      $display("FAIL split_commit got bv=%b p=%b ctrl=%h want 1 %b %h",
               bValid, writePulse, ctrlRegs, ep, packed_model());
    end
    tick();
    read_txn(4'd2, 0, d, rr, rv, st, rva);
    n_checks++;
    if (d !== 32'h12345678 || rr !== 2'b00 || rv !== 1'b1) begin
      n_fail++;
      $display("FAIL split_read got=%h/%b want=12345678/00", d, rr);
    end
  endtask

  task automatic test_status_hold();
    logic [31:0] d;
    logic [1:0] r;
    logic rv, rva;
    bit st;
    statusRegs[31:0] = 32'hA5A5A5A5;
    read_txn(4'd4, 5, d, r, rv, st, rva);
    n_checks++;
    if (d !== 32'hA5A5A5A5 || r !== 2'b00 || rv !== 1'b1) begin
      n_fail++;
      $display("FAIL status_read got=%h/%b want=a5a5a5a5/00", d, r);
    end
    n_checks++;
    if (!st || rva !== 1'b0) begin
      n_fail++;
      $display("FAIL status_hold got stable=%0d rv_after=%b want 1 0",
               st, rva);
    end
  endtask

  task automatic test_errors();
    logic [1:0] r, er;
    logic [3:0] p, ep, pa;
    logic bv, bva, rv, rva;
    logic [127:0] regs;
    logic [31:0] d;
    bit st;
    logic [3:0] addrs [2] = '{4'd5, 4'd9};
    foreach (addrs[k]) begin
      model_write(addrs[k], $urandom, 4'hF, er, ep);
      write_txn(addrs[k], $urandom, 4'hF, 0, 1, r, p, bv, regs, bva, pa);
      n_checks++;
      if (r !== 2'b10 || p !== 4'b0 || regs !== packed_model()) begin
        n_fail++;
        $display("FAIL err_write addr=%0d got r=%b p=%b want 10 0000",
                 addrs[k], r, p);
      end
    end
    read_txn(4'd12, 1, d, r, rv, st, rva);
    n_checks++;
    if (r !== 2'b10 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL err_read got=%h/%b want=0/10", d, r);
    end
  endtask

`ifdef REG_SLAVE_WSTRB_EN
  task automatic test_wstrb();
    logic [1:0] r, er;
    logic [3:0] p, ep, pa;
    logic bv, bva;
    logic [127:0] regs;
    model_write(4'd0, 32'hFFFFFFFF, 4'hF, er, ep);
    write_txn(4'd0, 32'hFFFFFFFF, 4'hF, 0, 0, r, p, bv, regs, bva, pa);
    model_write(4'd0, 32'h0, 4'b0101, er, ep);
    write_txn(4'd0, 32'h0, 4'b0101, 0, 0, r, p, bv, regs, bva, pa);
    n_checks++;
    if (regs[31:0] !== 32'hFF00FF00 || regs !== packed_model()) begin
      n_fail++;
      $display("FAIL wstrb_merge got=%h want=ff00ff00", regs[31:0]);
    end
    model_write(4'd3, 32'h1234, 4'b0000, er, ep);
    write_txn(4'd3, 32'h1234, 4'b0000, 0, 0, r, p, bv, regs, bva, pa);
    n_checks++;
    if (r !== 2'b00 || p !== 4'b1000 || regs !== packed_model()) begin
      n_fail++;
      $display("FAIL wstrb_zero got r=%b p=%b want 00 1000", r, p);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [1:0] r, er;
    logic [3:0] p, ep, pa;
    logic bv, bva;
    logic [127:0] regs;
    bit quiet = 1;
    awValid = 1'b1;
    awAddr  = 4'd0;
    tick();
    awValid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    for (int c = 0; c < 3; c++) begin
      if (bValid !== 1'b0) quiet = 0;
      tick();
    end
    n_checks++;
    if (!quiet || ctrlRegs !== 128'h0) begin
      n_fail++;
      $display("FAIL rst_mid got quiet=%0d ctrl=%h want 1 0", quiet,
               ctrlRegs);
    end
    model_write(4'd0, 32'h1, 4'hF, er, ep);
    write_txn(4'd0, 32'h1, 4'hF, 0, 0, r, p, bv, regs, bva, pa);
    n_checks++;
    if (regs[31:0] !== 32'h1 || r !== 2'b00 || p !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_mid_write got=%h r=%b p=%b want 1 00 0001",
               regs[31:0], r, p);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] old_v, new_v;
    logic [1:0] er;
    logic [3:0] ep;
    old_v = model[3];
    new_v = $urandom;
    awValid = 1'b1;
    awAddr  = 4'd3;
    wValid  = 1'b1;
    wData   = new_v;
`ifdef REG_SLAVE_WSTRB_EN
    wStrb   = 4'hF;
`endif
    arValid = 1'b1;
    arAddr  = 4'd3;
    rReady  = 1'b0;
    bReady  = 1'b0;
    tick();
    {awValid, wValid, arValid} = 3'b000;
    model_write(4'd3, new_v, 4'hF, er, ep);
    n_checks++;
    if (rValid !== 1'b1 || rData !== old_v) begin
      n_fail++;
      $display("FAIL same_edge_read got=%h want=%h", rData, old_v);
    end
    n_checks++;
    if (bValid !== 1'b1 || ctrlRegs !== packed_model()) begin
      n_fail++;
      $display("FAIL same_edge_write got=%h want=%h", ctrlRegs,
               packed_model());
    end
    rReady = 1'b1;
    bReady = 1'b1;
    tick();
    rReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] er;
    logic [3:0] ep;
    logic [31:0] d;
    int pulses = 0;
    bReady = 1'b1;
    awValid = 1'b1;
    wValid  = 1'b1;
`ifdef REG_SLAVE_WSTRB_EN
    wStrb   = 4'hF;
`endif
    for (int c = 0; c < 8; c++) begin
      if (writePulse !== 4'b0) pulses++;
      if (awReady) begin
        d = $urandom;
        awAddr = 4'(c / 2);
        wData  = d;
        model_write(4'(c / 2), d, 4'hF, er, ep);
      end
      tick();
    end
    if (writePulse !== 4'b0) pulses++;
    awValid = 1'b0;
    wValid  = 1'b0;
    n_checks++;
    if (pulses != 4 || ctrlRegs !== packed_model()) begin
      n_fail++;
      $display("FAIL back_to_back got pulses=%0d ctrl=%h want 4 %h",
               pulses, ctrlRegs, packed_model());
    end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] r, er;
    logic [3:0] p, ep, pa, a, s;
    logic bv, bva, rv, rva;
    logic [127:0] regs, st_snap;
    logic [31:0] d, ed;
    bit st;
    int hold;
    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
`ifdef REG_SLAVE_WSTRB_EN
        s = 4'($urandom);
`else
        s = 4'hF;
`endif
        model_write(a, d, s, er, ep);
        write_txn(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                  r, p, bv, regs, bva, pa);
        n_checks++;
        if (r !== er || p !== ep || bv !== 1'b1 ||
            regs !== packed_model() || bva !== 1'b0 || pa !== 4'b0) begin
          n_fail++;
          $display("FAIL rand_write addr=%0d got r=%b p=%b ctrl=%h want %b %b %h",
                   a, r, p, regs, er, ep, packed_model());
        end
      end else begin
        statusRegs = {$urandom, $urandom, $urandom, $urandom};
        st_snap = statusRegs;
        model_read(a, st_snap, ed, er);
        hold = $urandom_range(0, 2);
        read_txn(a, hold, d, r, rv, st, rva);
        n_checks++;
        if (d !== ed || r !== er || rv !== 1'b1 || !st || rva !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_read addr=%0d got=%h/%b want=%h/%b",
                   a, d, r, ed, er);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    {awValid, wValid, arValid, bReady, rReady} = '0;
    awAddr = '0;
    arAddr = '0;
    wData  = '0;
`ifdef REG_SLAVE_WSTRB_EN
    wStrb  = '0;
`endif
    statusRegs = '0;
    test_reset();
    test_basic_write();
    test_split_write();
    test_status_hold();
    test_errors();
`ifdef REG_SLAVE_WSTRB_EN
    test_wstrb();
`endif
    test_reset_mid();
    test_same_edge();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_reg_slave.md
# axi_reg_slave

Parametrised register-bank slave providing valid/ready write-address, write-data, write-response, read-address and read-data channels. Exposes NUM_RW software-writable control registers to fabric logic and NUM_RO hardware-driven status registers to software. Replaces the fixed three-register, handshake-free slave in the encoder/speed-measurement top level, and adds error responses and per-register write pulses.

## Interface
- DATA_WIDTH, 32, register and bus data width; multiple of 8
- ADDR_WIDTH, 4, word address width; NUM_RW+NUM_RO <= 2**ADDR_WIDTH
- NUM_RW, 4, number of read/write control registers
- NUM_RO, 4, number of read-only status registers
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- awValid/awReady  in/out  1  write-address handshake; awAddr  in  ADDR_WIDTH
- wValid/wReady  in/out  1  write-data handshake; wData  in  DATA_WIDTH
- wStrb  in  DATA_WIDTH/8  byte-lane enables (present only with REG_SLAVE_WSTRB_EN)
- bValid/bReady  out/in  1  write-response handshake; bResp  out  2
- arValid/arReady  in/out  1  read-address handshake; arAddr  in  ADDR_WIDTH
- rValid/rReady  out/in  1  read-data handshake; rData  out  DATA_WIDTH; rResp  out  2
- ctrlRegs  out  NUM_RW*DATA_WIDTH  control registers, register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- statusRegs  in  NUM_RO*DATA_WIDTH  status inputs, same packing
- writePulse  out  NUM_RW  one-cycle strobe per control register committed

## Operation
- Address map (word addresses): 0..NUM_RW-1 control; NUM_RW..NUM_RW+NUM_RO-1 status; everything else unmapped.
- Responses: OKAY=2'b00, SLVERR=2'b10. Writes to status or unmapped addresses -> SLVERR, no state change. Reads of unmapped addresses -> SLVERR, rData=0.
- Write FSM: W_IDLE -> (aw and w handshakes on the same edge) W_RESP; W_IDLE -> (aw only) W_ADDR; W_IDLE -> (w only) W_DATA; W_ADDR -> (w handshake) W_RESP; W_DATA -> (aw handshake) W_RESP; W_RESP -> (bReady) W_IDLE.
- awReady is high in W_IDLE and W_DATA. wReady is high in W_IDLE and W_ADDR. Address and data are latched at their own handshake.
- Commit occurs on the edge entering W_RESP. In that state bValid=1 and bResp are held stable until bReady.
- Read FSM: R_IDLE (arReady=1) -> (arValid) R_DATA. In R_DATA, rValid=1 and arReady=0; rData/rResp are held stable until rReady, then R_IDLE.
- Read and write channels are fully independent.

## Timing
- Reset values: ctrlRegs=0, writePulse=0, bValid=0, rValid=0, bResp=0, rResp=0, rData=0, all readies 0 while rst is high. Readies rise in the first cycle after rst falls.
- Write latency: ctrlRegs updates and writePulse[i] is high in the cycle after the final aw/w handshake, which is also the first bValid cycle. writePulse lasts exactly one cycle.
- Read latency: rValid is high in the cycle after the ar handshake. Status is sampled on the handshake edge.
- Throughput: one write per 2 cycles (bReady held high); one read per 2 cycles (rReady held high).
- Same-edge read handshake and write commit to the same control register: the read returns the old value.
- rst mid-transaction: latched address/data are discarded, no response is issued, and both FSMs go to idle.
- bReady/rReady asserted before valid: no effect. Valid never depends combinationally on ready.

## Configuration
- REG_SLAVE_WSTRB_EN defined: the wStrb port exists. Only byte lanes with a set strobe are updated. wStrb=0 to a control address gives OKAY, with no data change but writePulse still asserted. Status/unmapped writes still return SLVERR.
- Not defined: no wStrb port, and every accepted write replaces the full word.

## Structure
- Package axi_reg_pkg holds:
  - resp_t (2-bit) with constants RESP_OKAY and RESP_SLVERR
  - wr_state_t enum {W_IDLE, W_ADDR, W_DATA, W_RESP}
  - rd_state_t enum {R_IDLE, R_DATA}
- One natural sub-module, reg_write_channel: the write FSM plus address/data latches, emitting a one-cycle commit with address, data and strobe.
- Read decode, the register array and response muxing stay in axi_reg_slave.

## Test plan
- Reset, then aw+w same cycle to addr 1 with 0xDEADBEEF, bReady=1 -> next cycle ctrlRegs[1]=0xDEADBEEF, writePulse=4'b0010, bResp=OKAY for exactly one cycle.
- aw to addr 2 at cycle 0, w with 0x12345678 at cycle 3 -> awReady low in cycles 1–3, commit and bValid at cycle 4; read addr 2 returns 0x12345678 with rResp=OKAY.
- statusRegs[0]=0xA5A5A5A5, read addr 4 with rReady held low 5 cycles -> rValid and rData stay stable throughout, arReady=0 throughout.
- Write to addr 5 (status) and addr 9 (unmapped); read addr 12 -> bResp=SLVERR twice with ctrlRegs unchanged; rResp=SLVERR, rData=0.
- With REG_SLAVE_WSTRB_EN: ctrlRegs[0]=0xFFFFFFFF, write 0x00000000 with wStrb=4'b0101 -> ctrlRegs[0]=0xFF00FF00.
- Assert rst while in W_ADDR -> no bValid; the following write to addr 0 with 0x1 completes normally with ctrlRegs[0]=0x1.
